// File: rtl/wave_recorder_if.sv
// Sample-in / RAM-write / status bundle between the audio path and wave_recorder.
interface wave_recorder_if #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned SAMPLE_W = 16
);
  logic                start;
  logic                stop;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_in;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_address;
  logic [SAMPLE_W-1:0] wr_data;
  logic [ADDR_W-1:0]   depth;
  logic                recording;
  logic                full;
  logic                done;

  modport slave (
    input  start, stop, sample_valid, sample_in,
    output wr_en, wr_address, wr_data, depth, recording, full, done
  );

  modport master (
    output start, stop, sample_valid, sample_in,
    input  wr_en, wr_address, wr_data, depth, recording, full, done
  );
endinterface

// File: rtl/wave_recorder.sv
// Records a sample stream into the sample RAM and publishes the take depth.
// Optional magnitude trigger on the first sample: macro WAVE_RECORDER_TRIGGER_EN.
module wave_recorder #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned THRESHOLD = 1024
) (
  input  logic            clock,
  input  logic            reset,
  wave_recorder_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [SAMPLE_W-1:0] THR      = SAMPLE_W'(THRESHOLD);

  typedef enum logic [1:0] {IDLE, ARMED, RECORD, FINISH} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_m1_c;
  logic [ADDR_W-1:0]   depth_q, depth_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                full_q, full_d;
  logic                done_q, done_d;
  logic                rec_q, rec_d;
  logic                qualify_c;

`ifdef WAVE_RECORDER_TRIGGER_EN
  logic [SAMPLE_W-1:0] mag_c;

  // |sample| with the most negative code saturated to the largest positive value
  always_comb begin
    if (bus.sample_in == {1'b1, {(SAMPLE_W-1){1'b0}}})
      mag_c = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (bus.sample_in[SAMPLE_W-1])
      mag_c = ~bus.sample_in + SAMPLE_W'(1);
    else
      mag_c = bus.sample_in;
    qualify_c = (mag_c >= THR);
  end
`else
  logic unused_threshold;
  assign unused_threshold = ^THR;
  assign qualify_c        = 1'b1;
`endif

  assign cnt_m1_c = cnt_q - CNT_W'(1);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.start) state_d = ARMED;
      ARMED: begin
        if (bus.sample_valid && qualify_c) state_d = bus.stop ? FINISH : RECORD;
        else if (bus.stop)                 state_d = IDLE;
      end
      RECORD: if ((bus.sample_valid && cnt_q == CNT_LAST) || bus.stop) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d     = cnt_q;
    depth_d   = depth_q;
    full_d    = full_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d  = '0;
          full_d = 1'b0;
        end
      end
      ARMED: begin
        if (bus.sample_valid && qualify_c) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = bus.sample_in;
          cnt_d     = CNT_W'(1);
        end
      end
      RECORD: begin
        if (bus.sample_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = bus.sample_in;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) full_d = 1'b1;
        end
      end
      FINISH:  depth_d = cnt_m1_c[ADDR_W-1:0];
      default: ;
    endcase
    done_d = (state_d == FINISH);
    rec_d  = (state_d == ARMED) || (state_d == RECORD);
  end

  // Output and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      depth_q   <= '0;
      full_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      rec_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      depth_q   <= depth_d;
      full_q    <= full_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      rec_q     <= rec_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_address = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.depth      = depth_q;
  assign bus.recording  = rec_q;
  assign bus.full       = full_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_wave_recorder.sv
// Directed self-checking bench for wave_recorder (ADDR_W=4 build, THRESHOLD=1024).
module tb_wave_recorder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   done_cnt;
  logic [3:0]  wa_q[$];
  logic [15:0] wd_q[$];

  wave_recorder_if #(.ADDR_W(4), .SAMPLE_W(16)) bus ();

  wave_recorder #(.ADDR_W(4), .SAMPLE_W(16), .THRESHOLD(1024)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write / done logger, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_address);
      wd_q.push_back(bus.wr_data);
    end
    if (bus.done) done_cnt++;
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
  endtask

  task automatic step(input logic s, input logic p, input logic v, input logic [15:0] d);
    bus.start        = s;
    bus.stop         = p;
    bus.sample_valid = v;
    bus.sample_in    = d;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.stop = 1'b0; bus.sample_valid = 1'b0; bus.sample_in = '0;
    rst_n = 1'b0;
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
    checks++; if (bus.depth !== 4'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", bus.depth); end
    checks++; if (bus.recording !== 1'b0) begin failures++; $display("FAIL reset_recording got=%b exp=0", bus.recording); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear_log();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    checks++; if (bus.recording !== 1'b1) begin failures++; $display("FAIL basic_recording got=%b exp=1", bus.recording); end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 16'(10 + i));
    step(1'b0, 1'b1, 1'b0, 16'h0);
    idle(3);
    checks++; if (wa_q.size() !== 5) begin failures++; $display("FAIL basic_nwrites got=%0d exp=5", wa_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < wa_q.size()) begin
        checks++; if (wa_q[i] !== 4'(i)) begin failures++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, wa_q[i], i); end
        checks++; if (wd_q[i] !== 16'(10 + i)) begin failures++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, wd_q[i], 10 + i); end
      end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
    checks++; if (bus.depth !== 4'd4) begin failures++; $display("FAIL basic_depth got=%0d exp=4", bus.depth); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL basic_full got=%b exp=0", bus.full); end
    checks++; if (bus.recording !== 1'b0) begin failures++; $display("FAIL basic_rec_end got=%b exp=0", bus.recording); end
  endtask

  task automatic test_stop_with_sample();
    clear_log();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, 16'd20);
    step(1'b0, 1'b0, 1'b1, 16'd21);
    step(1'b0, 1'b1, 1'b1, 16'd22);
    idle(3);
    checks++; if (wa_q.size() !== 3) begin failures++; $display("FAIL sws_nwrites got=%0d exp=3", wa_q.size()); end
    if (wa_q.size() == 3) begin
      checks++; if (wa_q[2] !== 4'd2 || wd_q[2] !== 16'd22) begin failures++; $display("FAIL sws_last got=%0d/%0d exp=2/22", wa_q[2], wd_q[2]); end
    end
    checks++; if (bus.depth !== 4'd2) begin failures++; $display("FAIL sws_depth got=%0d exp=2", bus.depth); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL sws_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_abort();
    clear_log();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    idle(3);
    checks++; if (wa_q.size() !== 0) begin failures++; $display("FAIL abort_nwrites got=%0d exp=0", wa_q.size()); end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
    checks++; if (bus.depth !== 4'd2) begin failures++; $display("FAIL abort_depth got=%0d exp=2", bus.depth); end
    checks++; if (bus.recording !== 1'b0) begin failures++; $display("FAIL abort_rec got=%b exp=0", bus.recording); end
  endtask

  task automatic test_ignored_start();
    clear_log();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, 16'd30);
    step(1'b1, 1'b0, 1'b1, 16'd31);
    step(1'b1, 1'b0, 1'b1, 16'd32);
    step(1'b0, 1'b1, 1'b1, 16'd33);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    idle(3);
    checks++; if (wa_q.size() !== 4) begin failures++; $display("FAIL istart_nwrites got=%0d exp=4", wa_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wa_q.size()) begin
        checks++; if (wa_q[i] !== 4'(i) || wd_q[i] !== 16'(30 + i)) begin failures++; $display("FAIL istart_w[%0d] got=%0d/%0d exp=%0d/%0d", i, wa_q[i], wd_q[i], i, 30 + i); end
      end
    end
    checks++; if (bus.depth !== 4'd3) begin failures++; $display("FAIL istart_depth got=%0d exp=3", bus.depth); end
    checks++; if (bus.recording !== 1'b0) begin failures++; $display("FAIL istart_finish_start got=%b exp=0", bus.recording); end
  endtask

  task automatic test_full();
    clear_log();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 16'(100 + i));
    idle(3);
    checks++; if (wa_q.size() !== 16) begin failures++; $display("FAIL full_nwrites got=%0d exp=16", wa_q.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i < wa_q.size()) begin
        checks++; if (wa_q[i] !== 4'(i) || wd_q[i] !== 16'(100 + i)) begin failures++; $display("FAIL full_w[%0d] got=%0d/%0d exp=%0d/%0d", i, wa_q[i], wd_q[i], i, 100 + i); end
      end
    end
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", bus.full); end
    checks++; if (bus.depth !== 4'd15) begin failures++; $display("FAIL full_depth got=%0d exp=15", bus.depth); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL full_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_trigger();
    logic [15:0] exp_d[$];
    clear_log();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL trig_full_clr got=%b exp=0", bus.full); end
    step(1'b0, 1'b0, 1'b1, 16'd100);
    step(1'b0, 1'b0, 1'b1, 16'(-500));
    step(1'b0, 1'b0, 1'b1, 16'(-2000));
    step(1'b0, 1'b0, 1'b1, 16'd50);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    idle(3);
`ifdef WAVE_RECORDER_TRIGGER_EN
    exp_d = '{16'hF830, 16'd50};
`else
    exp_d = '{16'd100, 16'hFE0C, 16'hF830, 16'd50};
`endif
    checks++; if (wa_q.size() !== exp_d.size()) begin failures++; $display("FAIL trig_nwrites got=%0d exp=%0d", wa_q.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < wa_q.size()) begin
        checks++; if (wa_q[i] !== 4'(i) || wd_q[i] !== exp_d[i]) begin failures++; $display("FAIL trig_w[%0d] got=%0d/%h exp=%0d/%h", i, wa_q[i], wd_q[i], i, exp_d[i]); end
      end
    end
    checks++; if (bus.depth !== 4'(exp_d.size() - 1)) begin failures++; $display("FAIL trig_depth got=%0d exp=%0d", bus.depth, exp_d.size() - 1); end
  endtask

  task automatic test_reset_mid_take();
    clear_log();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, 16'd1);
    step(1'b0, 1'b0, 1'b1, 16'd2);
    checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL rmid_pre_wr_en got=%b exp=1", bus.wr_en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL rmid_wr_en got=%b exp=0", bus.wr_en); end
    checks++; if (bus.depth !== 4'd0) begin failures++; $display("FAIL rmid_depth got=%0d exp=0", bus.depth); end
    checks++; if (bus.recording !== 1'b0) begin failures++; $display("FAIL rmid_recording got=%b exp=0", bus.recording); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", done_cnt); end
    clear_log();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, 16'd7);
    step(1'b0, 1'b0, 1'b1, 16'd8);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    idle(3);
    checks++; if (wa_q.size() !== 2) begin failures++; $display("FAIL rmid_nwrites got=%0d exp=2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wa_q[0] !== 4'd0 || wd_q[0] !== 16'd7) begin failures++; $display("FAIL rmid_first got=%0d/%0d exp=0/7", wa_q[0], wd_q[0]); end
    end
    checks++; if (bus.depth !== 4'd1) begin failures++; $display("FAIL rmid_depth_after got=%0d exp=1", bus.depth); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_stop_with_sample();
    test_abort();
    test_ignored_start();
    test_full();
    test_trigger();
    test_reset_mid_take();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
